// File: rtl/execute_cycle_if.sv
// Execute-stage bus: decoded E-stage controls and operands in, E->M register outputs and
// branch/stall signals out.
interface execute_cycle_if #(parameter int XLEN = 32);
  logic            RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, MulE, FlushE;
  logic [2:0]      ALUControlE;
  logic [1:0]      ForwardA_E, ForwardB_E;
  logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]      RD_E;
  logic            PCSrcE, StallE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]      RD_M;
  logic [XLEN-1:0] PCPlus4M, WriteDataM, ALU_ResultM;

  modport master (
    output RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, MulE, FlushE,
           ALUControlE, ForwardA_E, ForwardB_E, RD1_E, RD2_E, Imm_Ext_E, PCE,
           PCPlus4E, ResultW, RD_E,
    input  PCSrcE, StallE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM
  );

  modport slave (
    input  RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, MulE, FlushE,
           ALUControlE, ForwardA_E, ForwardB_E, RD1_E, RD2_E, Imm_Ext_E, PCE,
           PCPlus4E, ResultW, RD_E,
    output PCSrcE, StallE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           PCPlus4M, WriteDataM, ALU_ResultM
  );
endinterface

// File: rtl/execute_cycle.sv
// RV32 execute stage: forwarding muxes, ALU, branch-target adder, iterative shift-add MUL
// that stalls the front end, and the E->M pipeline register.
module execute_cycle #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  execute_cycle_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res;
  logic [XLEN-1:0] acc, mcand, mplier;
  logic [CW-1:0]   count;
  logic            zero, lt, start, bubble;

  // ALU_ResultM feeds back as the EX->EX forwarding source
  always_comb begin
    src_a = bus.RD1_E;
    case (bus.ForwardA_E)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = bus.ALU_ResultM;
      default: src_a = bus.RD1_E;
    endcase
    fwd_b = bus.RD2_E;
    case (bus.ForwardB_E)
      2'b01:   fwd_b = bus.ResultW;
      2'b10:   fwd_b = bus.ALU_ResultM;
      default: fwd_b = bus.RD2_E;
    endcase
    src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
  end

  assign lt = $signed(src_a) < $signed(src_b);

  always_comb begin
    alu_res = '0;
    case (bus.ALUControlE)
      3'b000:  alu_res = src_a + src_b;
      3'b001:  alu_res = src_a - src_b;
      3'b010:  alu_res = src_a & src_b;
      3'b011:  alu_res = src_a | src_b;
      3'b101:  alu_res = {{(XLEN-1){1'b0}}, lt};
      default: alu_res = '0;
    endcase
  end

  assign zero          = (alu_res == '0);
  assign bus.PCSrcE    = bus.BranchE & zero & ~bus.MulE & ~bus.FlushE;
  assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

  // Flush beats everything, including the stall of an in-flight multiply
  assign start      = (state == S_IDLE) & bus.MulE & ~bus.FlushE;
  assign bus.StallE = start | ((state == S_BUSY) & ~bus.FlushE);
  assign bubble     = bus.StallE | bus.FlushE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (bus.FlushE) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.MulE) begin
          mcand  <= src_a;
          mplier <= src_b;
          acc    <= '0;
          count  <= '0;
          state  <= S_BUSY;
        end
        S_BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == LAST) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      bus.RegWriteM   <= 1'b0;
      bus.MemWriteM   <= 1'b0;
      bus.ResultSrcM  <= 1'b0;
      bus.RD_M        <= '0;
      bus.PCPlus4M    <= '0;
      bus.WriteDataM  <= '0;
      bus.ALU_ResultM <= '0;
    end else begin
      bus.RegWriteM   <= bus.RegWriteE;
      bus.MemWriteM   <= bus.MemWriteE;
      bus.ResultSrcM  <= bus.ResultSrcE;
      bus.RD_M        <= bus.RD_E;
      bus.PCPlus4M    <= bus.PCPlus4E;
      bus.WriteDataM  <= fwd_b;
      bus.ALU_ResultM <= (state == S_DONE) ? acc : alu_res;
    end
  end
endmodule

// File: tb/tb_execute_cycle.sv
// Directed + randomized bench for execute_cycle against a behavioural model of the stage.
module tb_execute_cycle;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] m_alu = '0;

  execute_cycle_if #(.XLEN(32)) bus ();
  execute_cycle #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd_ref(input logic [1:0] s, input logic [31:0] rf,
                                          input logic [31:0] w, input logic [31:0] m);
    return (s == 2'b01) ? w : (s == 2'b10) ? m : rf;
  endfunction

  task automatic drive(input logic rw, mw, rs, br, as, mul, fl, input logic [2:0] op,
                       input logic [1:0] fa, fb, input logic [31:0] rd1, rd2, imm, pc, resw,
                       input logic [4:0] rd);
    bus.RegWriteE = rw;  bus.MemWriteE = mw;  bus.ResultSrcE = rs;
    bus.BranchE = br;    bus.ALUSrcE = as;    bus.MulE = mul;   bus.FlushE = fl;
    bus.ALUControlE = op; bus.ForwardA_E = fa; bus.ForwardB_E = fb;
    bus.RD1_E = rd1; bus.RD2_E = rd2; bus.Imm_Ext_E = imm; bus.PCE = pc;
    bus.PCPlus4E = pc + 32'd4; bus.ResultW = resw; bus.RD_E = rd;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 5'd0);
  endtask

  task automatic expect_m(input string tag, input logic rw, mw, rs, input logic [4:0] rd,
                          input logic [31:0] pc4, wd, alu);
    chk({tag, ".RegWriteM"},   {31'd0, bus.RegWriteM},  {31'd0, rw});
    chk({tag, ".MemWriteM"},   {31'd0, bus.MemWriteM},  {31'd0, mw});
    chk({tag, ".ResultSrcM"},  {31'd0, bus.ResultSrcM}, {31'd0, rs});
    chk({tag, ".RD_M"},        {27'd0, bus.RD_M},       {27'd0, rd});
    chk({tag, ".PCPlus4M"},    bus.PCPlus4M,   pc4);
    chk({tag, ".WriteDataM"},  bus.WriteDataM, wd);
    chk({tag, ".ALU_ResultM"}, bus.ALU_ResultM, alu);
    m_alu = alu;
  endtask

  // One non-multiply instruction through E, checked against the model
  task automatic step_alu(input string tag, input logic rw, mw, rs, br, as, input logic [2:0] op,
                          input logic [1:0] fa, fb, input logic [31:0] rd1, rd2, imm, pc, resw,
                          input logic [4:0] rd);
    logic [31:0] a, b, bb, res;
    drive(rw, mw, rs, br, as, 0, 0, op, fa, fb, rd1, rd2, imm, pc, resw, rd);
    a   = fwd_ref(fa, rd1, resw, m_alu);
    b   = fwd_ref(fb, rd2, resw, m_alu);
    bb  = as ? imm : b;
    res = alu_ref(op, a, bb);
    #1;
    chk({tag, ".StallE"},    {31'd0, bus.StallE}, 32'd0);
    chk({tag, ".PCSrcE"},    {31'd0, bus.PCSrcE}, {31'd0, br && (res == 0)});
    chk({tag, ".PCTargetE"}, bus.PCTargetE, imm + pc);
    tick();
    expect_m(tag, rw, mw, rs, rd, pc + 32'd4, b, res);
  endtask

  task automatic do_mul(input string tag, input logic [31:0] a, b, input logic [4:0] rd);
    drive(1, 0, 0, 0, 0, 1, 0, 3'd0, 2'd0, 2'd0, a, b, 32'd0, 32'h200, 0, rd);
    for (int i = 0; i < 33; i++) begin
      #1;
      chk({tag, ".stall"}, {31'd0, bus.StallE}, 32'd1);
      tick();
      chk({tag, ".bubble_rw"},  {31'd0, bus.RegWriteM}, 32'd0);
      chk({tag, ".bubble_alu"}, bus.ALU_ResultM, 32'd0);
    end
    chk({tag, ".done_stall"}, {31'd0, bus.StallE}, 32'd0);
    tick();
    expect_m(tag, 1, 0, 0, rd, 32'h204, b, a * b);
    nop();
  endtask

  initial begin
    nop();
    #1;
    expect_m("reset", 0, 0, 0, 5'd0, 0, 0, 0);
    chk("reset.StallE", {31'd0, bus.StallE}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    step_alu("add",  1, 0, 0, 0, 0, 3'd0, 2'd0, 2'd0, 5, 7, 0, 32'h10, 0, 5'd3);
    step_alu("fwdA", 1, 0, 0, 0, 0, 3'd1, 2'd2, 2'd0, 0, 2, 0, 32'h14, 0, 5'd4);
    step_alu("fwdB", 1, 1, 1, 0, 0, 3'd0, 2'd0, 2'd1, 1, 0, 0, 32'h18, 32'h20, 5'd5);
    step_alu("slt",  1, 0, 0, 0, 1, 3'd5, 2'd0, 2'd0, 32'hFFFF_FFF0, 0, 32'd3, 32'h1C, 0, 5'd6);
    step_alu("beq",  0, 0, 0, 1, 0, 3'd1, 2'd0, 2'd0, 9, 9, 32'h40, 32'h100, 0, 5'd0);
    step_alu("bne",  0, 0, 0, 1, 0, 3'd1, 2'd0, 2'd0, 9, 8, 32'h40, 32'h100, 0, 5'd0);

    do_mul("mul7x6", 7, 6, 5'd8);
    do_mul("mulneg", 32'hFFFF_FFFF, 3, 5'd9);
    do_mul("b2b_a", 3, 4, 5'd10);
    do_mul("b2b_b", 5, 5, 5'd11);
    for (int k = 0; k < 3; k++)
      do_mul("mulrnd", $urandom, $urandom, 5'($urandom_range(1, 31)));

    // flush during BUSY: no product may ever reach M
    drive(1, 0, 0, 0, 0, 1, 0, 3'd0, 2'd0, 2'd0, 9, 9, 0, 32'h300, 0, 5'd12);
    for (int i = 0; i < 11; i++) tick();
    bus.FlushE = 1'b1;
    #1;
    chk("flush.StallE", {31'd0, bus.StallE}, 32'd0);
    chk("flush.PCSrcE", {31'd0, bus.PCSrcE}, 32'd0);
    tick();
    expect_m("flush", 0, 0, 0, 5'd0, 0, 0, 0);
    nop();
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("flush.no_prod", bus.ALU_ResultM, 32'd0);
      chk("flush.no_stall", {31'd0, bus.StallE}, 32'd0);
    end

    // asynchronous reset clears M between clock edges
    step_alu("pre_rst", 1, 1, 1, 0, 0, 3'd0, 2'd0, 2'd0, 32'h11, 32'h22, 0, 32'h40, 0, 5'd7);
    rst = 1'b1;
    #1;
    expect_m("async_rst", 0, 0, 0, 5'd0, 0, 0, 0);
    tick();
    rst = 1'b0;

    // reset mid-multiply aborts it
    drive(1, 0, 0, 0, 0, 1, 0, 3'd0, 2'd0, 2'd0, 11, 13, 0, 32'h400, 0, 5'd13);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    nop();
    #1;
    chk("rstmul.StallE", {31'd0, bus.StallE}, 32'd0);
    expect_m("rstmul", 0, 0, 0, 5'd0, 0, 0, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("rstmul.no_prod", bus.ALU_ResultM, 32'd0);
      chk("rstmul.no_stall", {31'd0, bus.StallE}, 32'd0);
    end

    // simultaneous FlushE + MulE in IDLE: no start, bubble
    drive(1, 1, 1, 0, 0, 1, 1, 3'd0, 2'd0, 2'd0, 4, 4, 0, 32'h500, 0, 5'd14);
    #1;
    chk("flmul.StallE", {31'd0, bus.StallE}, 32'd0);
    tick();
    expect_m("flmul", 0, 0, 0, 5'd0, 0, 0, 0);
    step_alu("after_flmul", 1, 0, 0, 0, 0, 3'd0, 2'd0, 2'd0, 1, 2, 0, 32'h504, 0, 5'd15);

    for (int k = 0; k < 40; k++)
      step_alu("rnd", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               (k % 4 == 0) ? 32'd5 : $urandom, (k % 4 == 0) ? 32'd5 : $urandom, $urandom,
               $urandom, $urandom, 5'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
Execute stage of the 5-stage RV32 pipeline. It sits between the decode/execute pipeline register and memory_cycle, and produces memory_cycle's inputs through the E->M pipeline register. It contains:
- operand forwarding muxes
- the ALU and the branch-target adder
- an iterative 32-cycle shift-add multiplier (MUL, low 32 bits) that stalls the front end while busy.

Parameters:
XLEN, 32, datapath width; multiplier iteration count equals XLEN.

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-high reset
RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE  in  1 each  decoded controls
MulE  in  1  instruction is MUL
FlushE  in  1  kill the instruction in E (from hazard unit)
ALUControlE  in  3  ALU op select
ForwardA_E, ForwardB_E  in  2 each  forwarding selects from hazard unit
RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW  in  XLEN each  operands, PC values, writeback result
RD_E  in  5  destination register
PCSrcE  out  1  branch taken (combinational)
PCTargetE  out  XLEN  PCE + Imm_Ext_E (combinational)
StallE  out  1  hold F/D/E registers (combinational)
RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls to memory_cycle
RD_M  out  5  registered destination
PCPlus4M, WriteDataM, ALU_ResultM  out  XLEN each  registered to memory_cycle

Behaviour:
Forwarding:
- SrcA: 00 -> RD1_E, 01 -> ResultW, 10 -> ALU_ResultM (own registered output), 11 -> RD1_E.
- Forwarded B uses the same encoding on RD2_E. WriteData = forwarded B.
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.

ALU:
- 000 add, 001 sub, 010 and, 011 or, 101 signed slt (result 0/1), other codes -> 0.
- Wraps modulo 2^XLEN; no overflow flag.
- Zero = (ALU result == 0).

Branch:
- PCSrcE = BranchE & Zero & ~MulE & ~FlushE.
- PCTargetE = PCE + Imm_Ext_E, wraps modulo 2^XLEN.

Multiplier FSM (states IDLE, BUSY, DONE):
- IDLE & MulE & ~FlushE:
  - StallE=1.
  - Latch mcand=SrcA, mplier=SrcB, acc=0, count=0.
  - Go to BUSY.
- BUSY:
  - StallE=1.
  - Each cycle: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, count++.
  - After XLEN iterations (count==XLEN-1 processed) go to DONE.
- DONE:
  - StallE=0.
  - E->M register captures acc as ALU_ResultM.
  - Go to IDLE.
- Occupancy and latency:
  - Total stage occupancy = XLEN+2 cycles (34).
  - Product visible on ALU_ResultM after the DONE edge.
- Operands are latched at start, so ResultW/forward changes during BUSY are ignored.
- Upstream holds all E inputs stable while StallE=1.

E->M register:
- Loads every cycle.
- While StallE=1, loads a bubble: RegWriteM=0, MemWriteM=0, ResultSrcM=0, RD_M=0, data fields=0. This lets the older instruction drain through M/W exactly once.
- FlushE=1 also loads a bubble.
- Otherwise loads the E values; ALU_ResultM = product in DONE, else ALU result.

FlushE precedence:
- Overrides everything.
- In BUSY or DONE: abort to IDLE, bubble loaded, StallE=0 that cycle.
- Simultaneous FlushE and MulE in IDLE: no start.

Reset:
- rst=1 asynchronously clears every registered output to 0, FSM to IDLE, acc/mcand/mplier/count to 0.
- Reset mid-multiply aborts the multiply; no partial result is ever written.
- StallE=0 during reset unless MulE is high in IDLE (combinational rule still applies after release).

Back-to-back MUL:
- The next MUL is presented the cycle after DONE and starts from IDLE normally.

Test Plan:
1. Reset then ADD: RD1_E=5, RD2_E=7, ALUControlE=000, RegWriteE=1, RD_E=3 -> after 1 edge: ALU_ResultM=12, RD_M=3, RegWriteM=1, StallE=0.
2. Forwarding: instr1 ADD producing 12; instr2 SUB with ForwardA_E=10, RD2_E=2 -> ALU_ResultM=10. Repeat with ForwardB_E=01, ResultW=0x20, ALUSrcE=0 -> WriteDataM=0x20.
3. Branch: BranchE=1, SUB with equal operands, PCE=0x100, Imm_Ext_E=0x40 -> PCSrcE=1, PCTargetE=0x140. Unequal operands -> PCSrcE=0.
4. MUL: SrcA=7, SrcB=6, MulE=1 held -> StallE=1 for 33 cycles with RegWriteM=0 bubbles; then ALU_ResultM=42, RegWriteM=1. Repeat 0xFFFFFFFF*3 -> 0xFFFFFFFD.
5. Abort cases:
   - FlushE pulsed at BUSY cycle 10 -> FSM IDLE, StallE=0, bubble in M, no product ever written.
   - rst pulsed mid-multiply -> all M outputs 0 immediately (asynchronous), FSM IDLE.
6. Simultaneous and back-to-back:
   - FlushE=1 with MulE=1 in IDLE -> no stall, bubble in M.
   - Two back-to-back MULs (3*4, 5*5) -> results 12 then 25, each after 34 cycles.
